// File: rtl/seq_alu_core.sv
// seq_alu_core: clocked, parametrised ALU launched by active-low push-buttons.
// Button presses are synchronised and edge-detected, then one operation runs per press.
// mul/div/mod run iteratively over N cycles; all other ops complete in one cycle.
// Optional feature macro: ACC_CHAIN_EN (mode 11 becomes an accumulator bank).
module seq_alu_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A_num,
    input  logic [N-1:0] B_num,
    input  logic [3:0]   operations_buttons,
    input  logic [1:0]   change_mode,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err,
    output logic         busy,
    output logic         done
);
    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [N:0]    N_V      = (N + 1)'(N);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4,  OP_AND = 4'd5,  OP_XOR = 4'd6,  OP_OR   = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ASR = 4'd10, OP_ROTL = 4'd11;
    localparam logic [3:0] OP_CLR = 4'd12, OP_ILL = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_t;

    state_t         state_q, state_d;
    logic [3:0]     sync1_q, sync2_q, prev_q;
    logic [3:0]     press;
    logic [1:0]     btn_idx;
    logic           launch;
    logic [1:0]     mode_q, btn_q;
    logic [N-1:0]   a_q, b_q;
    logic [3:0]     op_kind;
    logic           op_iter;
    logic [2*N-1:0] work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           err_q, err_d, done_q, done_d;

    // single-cycle datapath signals
    logic [N-1:0]   alu_r;
    logic           alu_c, alu_v;
    logic [N:0]     add_w, sub_w, shl_w, shr_w, asr_w, rot_amt;
    logic           big_shift;

    // iterative datapath signals
    logic [N:0]     mul_sum, div_shift;
    logic [N-1:0]   div_diff;
    logic [2*N-1:0] mul_step, div_step, iter_next;
    logic [N-1:0]   fin_r;
    logic           fin_cv;

    // Two-flop synchroniser plus previous-value register for falling-edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= operations_buttons;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press  = prev_q & ~sync2_q;
    assign launch = (state_q == S_IDLE) && (press != 4'b0000);

    // Lowest-index press wins when several buttons fall in the same cycle.
    always_comb begin
        btn_idx = 2'd3;
        if (press[0])      btn_idx = 2'd0;
        else if (press[1]) btn_idx = 2'd1;
        else if (press[2]) btn_idx = 2'd2;
    end

    // Latch operands and operation selection at launch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 2'b00;
            btn_q  <= 2'b00;
        end else if (launch) begin
`ifdef ACC_CHAIN_EN
            a_q    <= (change_mode == 2'b11) ? result_q : A_num;
`else
            a_q    <= A_num;
`endif
            b_q    <= B_num;
            mode_q <= change_mode;
            btn_q  <= btn_idx;
        end
    end

    // Decode bank/button into an operation kind.
    always_comb begin
        op_kind = OP_ILL;
        case ({mode_q, btn_q})
            4'b00_00: op_kind = OP_ADD;
            4'b00_01: op_kind = OP_SUB;
            4'b00_10: op_kind = OP_MUL;
            4'b00_11: op_kind = OP_DIV;
            4'b01_00: op_kind = OP_MOD;
            4'b01_01: op_kind = OP_AND;
            4'b01_10: op_kind = OP_XOR;
            4'b01_11: op_kind = OP_OR;
            4'b10_00: op_kind = OP_SHL;
            4'b10_01: op_kind = OP_SHR;
            4'b10_10: op_kind = OP_ASR;
            4'b10_11: op_kind = OP_ROTL;
`ifdef ACC_CHAIN_EN
            4'b11_00: op_kind = OP_ADD;
            4'b11_01: op_kind = OP_SUB;
            4'b11_10: op_kind = OP_MUL;
            4'b11_11: op_kind = OP_CLR;
`endif
            default:  op_kind = OP_ILL;
        endcase
        op_iter = (op_kind == OP_MUL) || (op_kind == OP_DIV) || (op_kind == OP_MOD);
    end

    // Single-cycle ALU; shifts are widened by one bit so the carry falls out naturally.
    always_comb begin
        alu_r     = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        add_w     = {1'b0, a_q} + {1'b0, b_q};
        sub_w     = {1'b0, a_q} - {1'b0, b_q};
        shl_w     = {1'b0, a_q} << b_q;
        shr_w     = {a_q, 1'b0} >> b_q;
        asr_w     = $signed({a_q, 1'b0}) >>> b_q;
        rot_amt   = {1'b0, b_q} % N_V;
        big_shift = ({1'b0, b_q} >= N_V);
        case (op_kind)
            OP_ADD: begin
                alu_r = add_w[N-1:0];
                alu_c = add_w[N];
                alu_v = (a_q[N-1] == b_q[N-1]) && (add_w[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                alu_r = sub_w[N-1:0];
                alu_c = ~sub_w[N];
                alu_v = (a_q[N-1] != b_q[N-1]) && (sub_w[N-1] != a_q[N-1]);
            end
            OP_AND: alu_r = a_q & b_q;
            OP_XOR: alu_r = a_q ^ b_q;
            OP_OR:  alu_r = a_q | b_q;
            OP_SHL: if (!big_shift) {alu_c, alu_r} = shl_w;
            OP_SHR: if (!big_shift) {alu_r, alu_c} = shr_w;
            OP_ASR: begin
                if (big_shift) alu_r = {N{a_q[N-1]}};
                else           {alu_r, alu_c} = asr_w;
            end
            OP_ROTL: begin
                alu_r = (a_q << rot_amt) | (a_q >> (N_V - rot_amt));
                alu_c = big_shift ? 1'b0 : shl_w[N];
            end
            default: ;
        endcase
    end

    // One step of shift-add multiply or restoring divide on the shared work register.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*N-1:N]} + {1'b0, a_q};
        mul_step  = work_q[0] ? {mul_sum, work_q[N-1:1]} : {1'b0, work_q[2*N-1:1]};
        div_shift = {work_q[2*N-1:N], work_q[N-1]};
        div_diff  = div_shift[N-1:0] - b_q;
        if (div_shift >= {1'b0, b_q}) div_step = {div_diff, work_q[N-2:0], 1'b1};
        else                          div_step = {div_shift[N-1:0], work_q[N-2:0], 1'b0};
        iter_next = (op_kind == OP_MUL) ? mul_step : div_step;
        fin_cv    = 1'b0;
        if (op_kind == OP_MUL) begin
            fin_r  = iter_next[N-1:0];
            fin_cv = (iter_next[2*N-1:N] != '0);
        end else if (b_q == '0) begin
            fin_r  = (op_kind == OP_DIV) ? {N{1'b1}} : a_q;
        end else begin
            fin_r  = (op_kind == OP_DIV) ? iter_next[N-1:0] : iter_next[2*N-1:N];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_EXEC;
            S_EXEC:  state_d = op_iter ? S_ITER : S_IDLE;
            S_ITER:  if (cnt_q == LAST_CNT) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the result, flags and iteration registers.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        done_d   = 1'b0;
        work_d   = work_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_EXEC: begin
                if (op_iter) begin
                    work_d = (op_kind == OP_MUL) ? {{N{1'b0}}, b_q} : {{N{1'b0}}, a_q};
                    cnt_d  = '0;
                end else begin
                    done_d = 1'b1;
                    if (op_kind == OP_ILL) begin
                        flags_d = 4'b0000;
                        err_d   = 1'b1;
                    end else begin
                        result_d = alu_r;
                        flags_d  = {alu_r[N-1], (alu_r == '0), alu_c, alu_v};
                        err_d    = 1'b0;
                    end
                end
            end
            S_ITER: begin
                work_d = iter_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    done_d   = 1'b1;
                    result_d = fin_r;
                    flags_d  = {fin_r[N-1], (fin_r == '0), fin_cv, fin_cv};
                    err_d    = (op_kind != OP_MUL) && (b_q == '0);
                end
            end
            default: ;
        endcase
    end

    // Result, flag and iteration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            done_q   <= done_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign err    = err_q;
    assign done   = done_q;
    assign busy   = (state_q == S_ITER);

endmodule

// File: tb/tb_seq_alu_core.sv
// Scoreboard bench for seq_alu_core (N=4): stimulus pushes expected responses,
// a monitor pops and compares on every done pulse, including the done cycle.
module tb_seq_alu_core;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] A_num = '0;
    logic [N-1:0] B_num = '0;
    logic [3:0]   operations_buttons = 4'hF;
    logic [1:0]   change_mode = 2'b00;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         err, busy, done;

    seq_alu_core #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .A_num(A_num), .B_num(B_num),
        .operations_buttons(operations_buttons), .change_mode(change_mode),
        .result(result), .flags(flags), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] f;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    exp_t  mon_e;
    string mon_nm;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", what, act, req);
        end
    endfunction

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
            end else begin
                mon_e  = sb.pop_front();
                mon_nm = nm_q.pop_front();
                $display("txn %-8s cyc=%0d result=%b flags=%b err=%b", mon_nm, cyc, result, flags, err);
                chk({mon_nm, "_result"}, 32'(result), 32'(mon_e.r));
                chk({mon_nm, "_flags"},  32'(flags),  32'(mon_e.f));
                chk({mon_nm, "_err"},    32'(err),    32'(mon_e.e));
                chk({mon_nm, "_cycle"},  32'(cyc),    32'(mon_e.cyc));
            end
        end
    end

    // Press the buttons in mask (bank mode) with operands a/b; expect done lat cycles after the sampling edge.
    task automatic issue(input string nm, input logic [1:0] mode, input logic [3:0] mask,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic [3:0] ef, input logic ee, input int lat);
        @(negedge clk);
        A_num = a;
        B_num = b;
        change_mode = mode;
        operations_buttons = ~mask;
        sb.push_back('{r: er, f: ef, e: ee, cyc: cyc + 1 + lat});
        nm_q.push_back(nm);
        repeat (3) @(negedge clk);
        operations_buttons = 4'hF;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending responses, want 0", sb.size());
            sb.delete();
            nm_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flags",  32'(flags),  32'h0);
        chk("rst_err",    32'(err),    32'h0);
        chk("rst_busy",   32'(busy),   32'h0);
        chk("rst_done",   32'(done),   32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue("add",    2'b00, 4'b0001, 4'b1011, 4'b0110, 4'b0001, 4'b0010, 1'b0, 3); wait_idle();
        issue("sub",    2'b00, 4'b0010, 4'b1111, 4'b1111, 4'b0000, 4'b0110, 1'b0, 3); wait_idle();

        // mul with a second press while busy, which must be ignored
        @(negedge clk);
        A_num = 4'b0101; B_num = 4'b0011; change_mode = 2'b00;
        operations_buttons = ~4'b0100;
        sb.push_back('{r: 4'b1111, f: 4'b1000, e: 1'b0, cyc: cyc + 1 + 7});
        nm_q.push_back("mul");
        repeat (3) @(negedge clk);
        operations_buttons = 4'hF;
        @(negedge clk);
        chk("mul_busy_first", 32'(busy), 32'h1);
        operations_buttons = ~4'b0001;
        repeat (2) @(negedge clk);
        operations_buttons = 4'hF;
        @(negedge clk);
        chk("mul_busy_late", 32'(busy), 32'h1);
        wait_idle();
        chk("mul_busy_end", 32'(busy), 32'h0);

        issue("div",    2'b00, 4'b1000, 4'b0011, 4'b0010, 4'b0001, 4'b0000, 1'b0, 7); wait_idle();
        issue("div0",   2'b00, 4'b1000, 4'b0110, 4'b0000, 4'b1111, 4'b1000, 1'b1, 7); wait_idle();
        issue("mod",    2'b01, 4'b0001, 4'b1001, 4'b0110, 4'b0011, 4'b0000, 1'b0, 7); wait_idle();
        issue("shl",    2'b10, 4'b0001, 4'b1010, 4'b0011, 4'b0000, 4'b0110, 1'b0, 3); wait_idle();
        issue("asr",    2'b10, 4'b0100, 4'b1100, 4'b0101, 4'b1111, 4'b1000, 1'b0, 3); wait_idle();
        issue("shr",    2'b10, 4'b0010, 4'b1011, 4'b0001, 4'b0101, 4'b0010, 1'b0, 3); wait_idle();
        issue("rotl",   2'b10, 4'b1000, 4'b1001, 4'b0101, 4'b0011, 4'b0000, 1'b0, 3); wait_idle();
        issue("and",    2'b01, 4'b0010, 4'b1100, 4'b1010, 4'b1000, 4'b1000, 1'b0, 3); wait_idle();
        issue("xor",    2'b01, 4'b0100, 4'b1100, 4'b1010, 4'b0110, 4'b0000, 1'b0, 3); wait_idle();
        issue("or",     2'b01, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 3); wait_idle();
        issue("add_ov", 2'b00, 4'b0001, 4'b0111, 4'b0001, 4'b1000, 4'b1001, 1'b0, 3); wait_idle();
        issue("sub_bw", 2'b00, 4'b0010, 4'b0010, 4'b0011, 4'b1111, 4'b1000, 1'b0, 3); wait_idle();
        issue("mul_ov", 2'b00, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0111, 1'b0, 7); wait_idle();
        issue("multi",  2'b01, 4'b0110, 4'b1100, 4'b1010, 4'b1000, 4'b1000, 1'b0, 3); wait_idle();

`ifdef ACC_CHAIN_EN
        issue("seed",   2'b01, 4'b1000, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 1'b0, 3); wait_idle();
        issue("acc_add",2'b11, 4'b0001, 4'b1111, 4'b0010, 4'b0101, 4'b0000, 1'b0, 3); wait_idle();
        issue("acc_mul",2'b11, 4'b0100, 4'b0000, 4'b0011, 4'b1111, 4'b1000, 1'b0, 7); wait_idle();
        issue("acc_clr",2'b11, 4'b1000, 4'b0110, 4'b0110, 4'b0000, 4'b0100, 1'b0, 3); wait_idle();
`else
        issue("mode3",  2'b11, 4'b0001, 4'b0101, 4'b0101, 4'b1000, 4'b0000, 1'b1, 3); wait_idle();
        issue("add_ok", 2'b00, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 1'b0, 3); wait_idle();
`endif
        issue("pre_rst",2'b01, 4'b1000, 4'b0101, 4'b0010, 4'b0111, 4'b0000, 1'b0, 3); wait_idle();

        // reset during busy cycle 2 of a mul: outputs clear, no done pulse
        @(negedge clk);
        A_num = 4'b0011; B_num = 4'b0011; change_mode = 2'b00;
        operations_buttons = ~4'b0100;
        repeat (3) @(negedge clk);
        operations_buttons = 4'hF;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_result", 32'(result), 32'h0);
        chk("abort_flags",  32'(flags),  32'h0);
        chk("abort_err",    32'(err),    32'h0);
        chk("abort_busy0",  32'(busy),   32'h0);
        chk("abort_done",   32'(done),   32'h0);
        repeat (12) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
